// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the 640x480@60 VGA timing/output path.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: one-clk pix_tick per CLK_DIV clocks plus a registered DAC pixel clock.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick,
    output logic vga_clk
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_nxt;

    always_comb begin
        div_nxt = div_cnt + CW'(1);
        if (div_cnt == CW'(CLK_DIV - 1)) begin
            div_nxt = '0;
        end
    end

    // vga_clk is computed from the next count so the register lines up with div_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            vga_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            vga_clk <= (div_nxt >= CW'(CLK_DIV / 2));
        end
    end

    assign pix_tick = (div_cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/vga_timing_out.sv
// VGA scan counters, sync/blank decode and DAC output stage.
// Optional VGA_PIPE_ALIGN_EN adds one pixel-tick register on sync, blank and RGB pins.
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n
);

    localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    coord_t x_cnt;
    coord_t y_cnt;
    logic   x_wrap;
    logic   y_wrap;
    logic   hs_c;
    logic   vs_c;
    rgb_t   rgb_c;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick),
        .vga_clk  (vga_clk)
    );

    assign x_wrap = (x_cnt == coord_t'(H_TOTAL - 1));
    assign y_wrap = (y_cnt == coord_t'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_tick) begin
            if (x_wrap) begin
                x_cnt <= '0;
                y_cnt <= y_wrap ? coord_t'(0) : y_cnt + coord_t'(1);
            end else begin
                x_cnt <= x_cnt + coord_t'(1);
            end
        end
    end

    assign x           = x_cnt;
    assign y           = y_cnt;
    assign active      = (x_cnt < coord_t'(H_ACTIVE)) && (y_cnt < coord_t'(V_ACTIVE));
    assign line_start  = pix_tick && x_wrap;
    assign frame_start = pix_tick && x_wrap && y_wrap;

    assign hs_c  = !((x_cnt >= coord_t'(HS_FIRST)) && (x_cnt <= coord_t'(HS_LAST)));
    assign vs_c  = !((y_cnt >= coord_t'(VS_FIRST)) && (y_cnt <= coord_t'(VS_LAST)));
    assign rgb_c = active ? rgb_t'{r: r_in, g: g_in, b: b_in} : rgb_t'('0);

    assign vga_sync_n = 1'b0;

`ifdef VGA_PIPE_ALIGN_EN
    logic hs_p1;
    logic vs_p1;
    logic blank_p1;
    rgb_t rgb_p1;

    // Output stage p1: capture the decoded pixel on pix_tick, shown during the next pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_p1    <= 1'b1;
            vs_p1    <= 1'b1;
            blank_p1 <= 1'b0;
            rgb_p1   <= '0;
        end else if (pix_tick) begin
            hs_p1    <= hs_c;
            vs_p1    <= vs_c;
            blank_p1 <= active;
            rgb_p1   <= rgb_c;
        end
    end

    assign vga_hs      = hs_p1;
    assign vga_vs      = vs_p1;
    assign vga_blank_n = blank_p1;
    assign vga_r       = rgb_p1.r;
    assign vga_g       = rgb_p1.g;
    assign vga_b       = rgb_p1.b;
`else
    // The reset state is pixel (0,0), which is visible; hold pins dark while rst is high
    logic show;
    assign show        = active && !rst;
    assign vga_hs      = hs_c;
    assign vga_vs      = vs_c;
    assign vga_blank_n = show;
    assign vga_r       = show ? rgb_c.r : 8'h00;
    assign vga_g       = show ? rgb_c.g : 8'h00;
    assign vga_b       = show ? rgb_c.b : 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: default-timing instance plus a shrunken-timing instance (CLK_DIV=4).
module tb_vga_timing_out;

`ifdef VGA_PIPE_ALIGN_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    localparam int SHA = 20, SHF = 4, SHS = 6, SHB = 5;
    localparam int SVA = 8, SVF = 2, SVS = 2, SVB = 3;
    localparam int SCD = 4;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        tick;
        logic        vclk;
        logic        ls;
        logic        fs;
        logic        act;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mode = 1'b0;
    bit   chk_en = 1'b0;
    bit   phase = 1'b0;
    int   k = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   hs_lo_d = 0;
    int   vs_lo_s = 0;
    int   last_fs = -1;
    int   fs_int = -1;

    logic       tick_d, act_d, ls_d, fs_d, vclk_d, hs_d, vs_d, bn_d, sn_d;
    logic [9:0] x_d, y_d;
    logic [7:0] r_in_d, g_in_d, b_in_d, vr_d, vg_d, vb_d;
    logic       tick_s, act_s, ls_s, fs_s, vclk_s, hs_s, vs_s, bn_s, sn_s;
    logic [9:0] x_s, y_s;
    logic [7:0] r_in_s, g_in_s, b_in_s, vr_s, vg_s, vb_s;

    always #5 clk = ~clk;

    function automatic logic [23:0] colour(input bit md, input int cx, input int cy);
        if (!md) return 24'hFFFFFF;
        return {cx[7:0] ^ 8'h5A, cy[7:0] + 8'h11, cx[7:0] + cy[7:0]};
    endfunction

    always_comb {r_in_d, g_in_d, b_in_d} = colour(mode, int'(x_d), int'(y_d));
    always_comb {r_in_s, g_in_s, b_in_s} = colour(mode, int'(x_s), int'(y_s));

    vga_timing_out dut_d (
        .clk(clk), .rst(rst), .pix_tick(tick_d), .x(x_d), .y(y_d), .active(act_d),
        .line_start(ls_d), .frame_start(fs_d), .r_in(r_in_d), .g_in(g_in_d), .b_in(b_in_d),
        .vga_r(vr_d), .vga_g(vg_d), .vga_b(vb_d), .vga_clk(vclk_d), .vga_hs(hs_d),
        .vga_vs(vs_d), .vga_blank_n(bn_d), .vga_sync_n(sn_d)
    );

    vga_timing_out #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CLK_DIV(SCD)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_tick(tick_s), .x(x_s), .y(y_s), .active(act_s),
        .line_start(ls_s), .frame_start(fs_s), .r_in(r_in_s), .g_in(g_in_s), .b_in(b_in_s),
        .vga_r(vr_s), .vga_g(vg_s), .vga_b(vb_s), .vga_clk(vclk_s), .vga_hs(hs_s),
        .vga_vs(vs_s), .vga_blank_n(bn_s), .vga_sync_n(sn_s)
    );

    // Clocks elapsed since the last edge that saw rst high
    always @(posedge clk) k <= rst ? 0 : k + 1;

    // Pixel p = k/cd is shown on the counters; pins show pixel p (or p-1 when pipelined)
    function automatic exp_t model(input int kk, input int cd, input int ha, input int hf,
                                   input int hw, input int hb, input int va, input int vf,
                                   input int vw, input int vb, input bit in_rst, input bit md);
        exp_t e;
        int ht, vt, p, ph, q, qx, qy;
        bit dark;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        p  = kk / cd;
        ph = kk % cd;
        e.x    = 10'(p % ht);
        e.y    = 10'((p / ht) % vt);
        e.tick = (ph == cd - 1);
        e.vclk = (ph >= cd / 2);
        e.ls   = e.tick && (p % ht == ht - 1);
        e.fs   = e.ls && ((p / ht) % vt == vt - 1);
        e.act  = (p % ht < ha) && ((p / ht) % vt < va);
        if (PIPE) begin
            q = (p > 0) ? p - 1 : 0;
            dark = (p == 0);
        end else begin
            q = p;
            dark = in_rst;
        end
        qx = q % ht;
        qy = (q / ht) % vt;
        e.hs  = (PIPE && p == 0) ? 1'b1 : !(qx >= ha + hf && qx < ha + hf + hw);
        e.vs  = (PIPE && p == 0) ? 1'b1 : !(qy >= va + vf && qy < va + vf + vw);
        e.bn  = !dark && (qx < ha) && (qy < va);
        e.rgb = e.bn ? colour(md, qx, qy) : 24'h0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    always @(negedge clk) begin
        exp_t ed, es;
        if (chk_en) begin
            ed = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, rst, mode);
            es = model(k, SCD, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, rst, mode);
            check("d_xy", {x_d, y_d}, {ed.x, ed.y});
            check("d_ctrl", {tick_d, vclk_d, ls_d, fs_d, act_d}, {ed.tick, ed.vclk, ed.ls, ed.fs, ed.act});
            check("d_sync", {hs_d, vs_d, bn_d, sn_d}, {ed.hs, ed.vs, ed.bn, 1'b0});
            check("d_rgb", {vr_d, vg_d, vb_d}, ed.rgb);
            check("s_xy", {x_s, y_s}, {es.x, es.y});
            check("s_ctrl", {tick_s, vclk_s, ls_s, fs_s, act_s}, {es.tick, es.vclk, es.ls, es.fs, es.act});
            check("s_sync", {hs_s, vs_s, bn_s, sn_s}, {es.hs, es.vs, es.bn, 1'b0});
            check("s_rgb", {vr_s, vg_s, vb_s}, es.rgb);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst && !phase) begin
            if (k < 1600 && tick_d && !hs_d) hs_lo_d <= hs_lo_d + 1;
            if (k < 2100 && tick_s && !vs_s) vs_lo_s <= vs_lo_s + 1;
            if (fs_s) begin
                if (last_fs >= 0) fs_int <= k - last_fs;
                last_fs <= k;
            end
        end
    end

    task automatic wait_k(input int n);
        int guard = 0;
        while (k < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("reach_k", k, n);
    endtask

    initial begin
        rst = 1'b1;
        mode = 1'b0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_x", x_d, 10'd0);
        check("rst_y", y_d, 10'd0);
        check("rst_hs_vs", {hs_d, vs_d}, 2'b11);
        check("rst_blank_n", bn_d, 1'b0);
        check("rst_tick", tick_d, 1'b0);
        check("rst_rgb", {vr_d, vg_d, vb_d}, 24'h0);
        check("rst_s_blank_rgb", {bn_s, vr_s, vg_s, vb_s}, 25'h0);

        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("tick_after_rel0", tick_d, 1'b0);
        @(negedge clk);
        check("tick_after_rel1", tick_d, 1'b1);
        check("s_tick_k1", tick_s, 1'b0);
        @(negedge clk);
        check("x_after_tick", x_d, 10'd1);

        wait_k(1120);
        check("s_y_at_v_active", y_s, 10'd8);
        check("s_rgb_blank_y", {vr_s, vg_s, vb_s}, 24'h0);
        wait_k(1278);
        check("rgb_x639", {vr_d, vg_d, vb_d}, 24'hFFFFFF);
        wait_k(1282);
        check("rgb_x641", {vr_d, vg_d, vb_d}, 24'h0);
        wait_k(1312);
        check("hs_at_x656", hs_d, PIPE ? 1'b1 : 1'b0);
        wait_k(1314);
        check("hs_at_x657", hs_d, 1'b0);
        wait_k(1599);
        check("line_start_x799", {ls_d, fs_d, x_d}, {2'b10, 10'd799});
        wait_k(1600);
        check("line_wrap_xy", {x_d, y_d, ls_d}, {10'd0, 10'd1, 1'b0});
        check("hs_low_ticks", hs_lo_d, 96);

        wait_k(4300);
        check("s_frame_interval", fs_int, 2100);
        check("s_vs_low_ticks", vs_lo_s, 70);

        wait_k(4968);
        check("s_pre_rst_xy", {x_s, y_s}, {10'd17, 10'd5});
        phase = 1'b1;
        @(posedge clk); #1 rst = 1'b1; mode = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("s_mid_rst_xy", {x_s, y_s}, 20'd0);
        check("s_mid_rst_sync", {hs_s, vs_s}, 2'b11);
        check("d_mid_rst_xy", {x_d, y_d}, 20'd0);

        wait_k(4400);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
